// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display counters: counting modes,
// the active-low glyph table and the nibble-to-segment lookup.
package seg7_pkg;

  typedef enum logic {
    MODE_DEC = 1'b0,
    MODE_HEX = 1'b1
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 first so index == nibble.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw pushbutton, debounces it and emits a single-cycle
// registered pulse on each accepted press (release is silent).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser, disagreement counter, debounced level and press pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/seven_segment_multi_counter.sv
// Multi-digit BCD/hex up/down counter driving a multiplexed bank of
// common-anode seven-segment displays from debounced pushbuttons.
module seven_segment_multi_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS         = 4,
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int SCAN_CYCLES        = 100_000,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  increment_counter_btn_i,
  input  logic                  decrement_counter_btn_i,
  input  logic                  mode_select_switch_i,
  output logic [NUM_DIGITS-1:0] digital_select_o,
  output logic [6:0]            seven_bit_display_o,
  output logic                  wrap_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_CYCLES - 1);

  logic w_inc;
  logic w_dec;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_btn   (increment_counter_btn_i),
    .o_press (w_inc)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_btn   (decrement_counter_btn_i),
    .o_press (w_dec)
  );

  logic                       r_mode_sync1;
  logic                       r_mode_sync2;
  mode_e                      r_mode;
  logic                       w_mode_chg;
  logic [NUM_DIGITS-1:0][3:0] r_digits;
  logic [NUM_DIGITS-1:0][3:0] w_up;
  logic [NUM_DIGITS-1:0][3:0] w_down;
  logic [3:0]                 w_max;
  logic                       w_carry;
  logic                       w_borrow;
  logic                       w_up_wrap;
  logic                       w_down_wrap;
  logic                       r_wrap_evt;
  logic [PRE_W-1:0]           r_pre;
  logic [IDX_W-1:0]           r_idx;
  logic [NUM_DIGITS-1:0]      w_blank;
  logic                       w_upper_zero;
  logic [NUM_DIGITS-1:0]      r_sel;
  logic [6:0]                 r_seg;
  logic                       r_wrap;

  assign w_mode_chg = (mode_e'(r_mode_sync2) != r_mode);
  assign w_max      = (r_mode == MODE_HEX) ? 4'hF : 4'h9;

  // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
  always_comb begin
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    w_up     = r_digits;
    w_down   = r_digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (r_digits[i] == w_max) begin
          w_up[i] = 4'h0;
        end else begin
          w_up[i] = r_digits[i] + 4'h1;
          w_carry = 1'b0;
        end
      end else begin
        w_up[i] = r_digits[i];
      end
      if (w_borrow) begin
        if (r_digits[i] == 4'h0) begin
          w_down[i] = w_max;
        end else begin
          w_down[i] = r_digits[i] - 4'h1;
          w_borrow  = 1'b0;
        end
      end else begin
        w_down[i] = r_digits[i];
      end
    end
    w_up_wrap   = w_carry;
    w_down_wrap = w_borrow;
  end

  // Mode synchroniser and the counter itself; a mode change wins over presses.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_mode_sync1 <= 1'b0;
      r_mode_sync2 <= 1'b0;
      r_mode       <= MODE_DEC;
      r_digits     <= '0;
      r_wrap_evt   <= 1'b0;
    end else begin
      r_mode_sync1 <= mode_select_switch_i;
      r_mode_sync2 <= r_mode_sync1;
      r_mode       <= mode_e'(r_mode_sync2);
      r_wrap_evt   <= 1'b0;
      if (w_mode_chg) begin
        r_digits <= '0;
      end else if (w_inc && w_dec) begin
        r_digits <= r_digits;
      end else if (w_inc) begin
        r_digits   <= w_up;
        r_wrap_evt <= w_up_wrap;
      end else if (w_dec) begin
        r_digits   <= w_down;
        r_wrap_evt <= w_down_wrap;
      end else begin
        r_digits <= r_digits;
      end
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    w_blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero && (r_digits[i] == 4'h0);
      if ((LEADING_ZERO_BLANK != 0) && (i != 0)) begin
        w_blank[i] = w_upper_zero;
      end else begin
        w_blank[i] = 1'b0;
      end
    end
  end

  // Output flops keep the display pins glitch-free.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_sel  <= '1;
      r_seg  <= SEG_BLANK;
      r_wrap <= 1'b0;
    end else begin
      r_sel  <= ~(NUM_DIGITS'(1'b1) << r_idx);
      r_seg  <= w_blank[r_idx] ? SEG_BLANK : hex_to_seg(r_digits[r_idx]);
      r_wrap <= r_wrap_evt;
    end
  end

  assign digital_select_o    = r_sel;
  assign seven_bit_display_o = r_seg;
  assign wrap_o              = r_wrap;

endmodule

// File: tb/tb_seven_segment_multi_counter.sv
// Randomised bench for seven_segment_multi_counter: an integer-valued reference
// model predicts select, segment and wrap pins of a plain and a blanking instance.
module tb_seven_segment_multi_counter;

  localparam int N = 4;
  localparam int D = 4;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inc = 1'b0;
  logic         dec = 1'b0;
  logic         sw = 1'b0;
  logic [N-1:0] sel, sel_b;
  logic [6:0]   seg, seg_b;
  logic         wrap, wrap_b;

  always #5 clk = ~clk;

  seven_segment_multi_counter #(
    .NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .LEADING_ZERO_BLANK(0)
  ) u_dut (
    .clk_i                   (clk),
    .reset_n_i               (reset_n),
    .increment_counter_btn_i (inc),
    .decrement_counter_btn_i (dec),
    .mode_select_switch_i    (sw),
    .digital_select_o        (sel),
    .seven_bit_display_o     (seg),
    .wrap_o                  (wrap)
  );

  seven_segment_multi_counter #(
    .NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .LEADING_ZERO_BLANK(1)
  ) u_dut_lzb (
    .clk_i                   (clk),
    .reset_n_i               (reset_n),
    .increment_counter_btn_i (inc),
    .decrement_counter_btn_i (dec),
    .mode_select_switch_i    (sw),
    .digital_select_o        (sel_b),
    .seven_bit_display_o     (seg_b),
    .wrap_o                  (wrap_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: the count is one integer modulo base**N.
  int unsigned count;
  bit          hex_mode;
  bit          syncm_prev;
  bit          lvl_i, lvl_d, press_i, press_d, wrap_evt;
  int          k;
  int          hist_i[$], hist_d[$], hist_m[$];
  logic [N-1:0] exp_sel;
  logic [6:0]   exp_seg, exp_seg_b;
  logic         exp_wrap;

  function automatic int unsigned ipow(input int unsigned b, input int e);
    int unsigned r = 1;
    repeat (e) r = r * b;
    return r;
  endfunction

  // Level flips once the last D synchronised samples all disagree with it.
  task automatic debounce_step(input int q[$], inout bit lvl, output bit pls);
    bit differ = 1'b1;
    int sz = q.size();
    pls = 1'b0;
    if (sz - 2 - D < 0) differ = 1'b0;
    else for (int j = 0; j < D; j++) if (q[sz-3-j] == int'(lvl)) differ = 1'b0;
    if (differ) begin
      lvl = ~lvl;
      pls = lvl;
    end
  endtask

  task automatic model_step();
    int unsigned base, modulus, digit;
    int idx, syncm;
    if (!reset_n) begin
      k = 0; count = 0; hex_mode = 0; syncm_prev = 0;
      lvl_i = 0; lvl_d = 0; press_i = 0; press_d = 0; wrap_evt = 0;
      hist_i = '{0, 0}; hist_d = '{0, 0}; hist_m = '{0, 0};
      exp_sel = '1; exp_seg = 7'h7F; exp_seg_b = 7'h7F; exp_wrap = 1'b0;
    end else begin
      base    = hex_mode ? 16 : 10;
      modulus = ipow(base, N);
      idx     = (k / S) % N;
      digit   = (count / ipow(base, idx)) % base;
      exp_sel   = ~(N'(1) << idx);
      exp_seg   = glyph[digit];
      exp_seg_b = (idx > 0 && count < ipow(base, idx)) ? 7'h7F : glyph[digit];
      exp_wrap  = wrap_evt;
      hist_i.push_back(int'(inc));
      hist_d.push_back(int'(dec));
      hist_m.push_back(int'(sw));
      while (hist_i.size() > D + 3) begin
        void'(hist_i.pop_front()); void'(hist_d.pop_front()); void'(hist_m.pop_front());
      end
      syncm    = hist_m[hist_m.size()-3];
      wrap_evt = 0;
      if (syncm != int'(syncm_prev)) begin
        count = 0;
        hex_mode = syncm[0];
      end else if (press_i && press_d) begin
        count = count;
      end else if (press_i) begin
        if (count == modulus - 1) begin count = 0; wrap_evt = 1; end
        else count = count + 1;
      end else if (press_d) begin
        if (count == 0) begin count = modulus - 1; wrap_evt = 1; end
        else count = count - 1;
      end
      syncm_prev = syncm[0];
      debounce_step(hist_i, lvl_i, press_i);
      debounce_step(hist_d, lvl_d, press_d);
      k++;
    end
  endtask

  // Model advances on each rising edge; pins are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("select", 32'(sel), 32'(exp_sel));
      check_eq("segments", 32'(seg), 32'(exp_seg));
      check_eq("wrap", 32'(wrap), 32'(exp_wrap));
      check_eq("select_lzb", 32'(sel_b), 32'(exp_sel));
      check_eq("segments_lzb", 32'(seg_b), 32'(exp_seg_b));
      check_eq("wrap_lzb", 32'(wrap_b), 32'(exp_wrap));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the chosen buttons for 'hold' cycles; optionally flip the switch at cycle tog_at.
  task automatic press(input bit ui, input bit ud, input int hold, input int gap, input int tog_at);
    @(negedge clk);
    inc = ui;
    dec = ud;
    for (int j = 0; j < hold; j++) begin
      if (j == tog_at) sw = ~sw;
      @(negedge clk);
    end
    inc = 1'b0;
    dec = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic presses(input bit ui, input bit ud, input int n);
    for (int j = 0; j < n; j++) press(ui, ud, $urandom_range(4, 7), $urandom_range(5, 7), -1);
  endtask

  task automatic toggle_mode(input int gap);
    @(negedge clk);
    sw = ~sw;
    idle(gap);
  endtask

  initial begin
    reset_n = 1'b0;
    idle(5);
    reset_n = 1'b1;
    idle(70);                          // full scan rotation at count 0
    press(1, 0, 3, 10, -1);            // too short to register
    press(1, 0, 10, 10, -1);           // one increment
    @(negedge clk); inc = 1'b1; idle(2); inc = 1'b0; idle(1); inc = 1'b1; idle(6);
    inc = 1'b0; idle(10);              // glitch restarts debounce, then one press
    toggle_mode(8); toggle_mode(8);    // back to decimal, cleared
    presses(1, 0, 999);                // 0999
    presses(1, 0, 1);                  // 1000
    toggle_mode(8); toggle_mode(8);
    presses(0, 1, 1);                  // 0000 -> 9999, wrap
    idle(40);
    presses(1, 0, 1);                  // 9999 -> 0000, wrap
    presses(0, 1, 1);                  // wrap again
    presses(1, 1, 3);                  // simultaneous presses: no change
    toggle_mode(8);                    // hex
    presses(1, 0, 255);                // 00FF
    presses(1, 0, 1);                  // 0100
    toggle_mode(8); toggle_mode(8);
    presses(0, 1, 1);                  // FFFF, wrap
    idle(40);
    presses(1, 0, 1);                  // 0000, wrap
    toggle_mode(8);                    // decimal
    presses(1, 0, 42);
    idle(70);                          // blanking of digits 3,2 visible
    toggle_mode(10);                   // clears 0042
    presses(1, 0, 5);
    press(1, 0, 7, 10, 4);             // press pulse coincides with mode clear
    for (int a = 0; a < 300; a++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press(1, 0, $urandom_range(1, 8), $urandom_range(1, 8), -1);
        4, 5:       press(0, 1, $urandom_range(1, 8), $urandom_range(1, 8), -1);
        6:          press(1, 1, $urandom_range(3, 8), $urandom_range(4, 8), -1);
        7:          toggle_mode($urandom_range(1, 10));
        8:          press($urandom_range(0, 1), 1, $urandom_range(4, 8), 6, $urandom_range(0, 6));
        default: begin
          @(negedge clk); inc = 1'b1; idle($urandom_range(1, 4));
          reset_n = 1'b0; inc = 1'b0; idle($urandom_range(1, 3));
          reset_n = 1'b1; idle($urandom_range(1, 20));
        end
      endcase
    end
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_multi_counter.md
# seven_segment_multi_counter

Parametrised successor to the single-mode lab display counter. Drives a multiplexed bank of NUM_DIGITS common-anode seven-segment displays from a NUM_DIGITS-digit up/down counter with selectable decimal (BCD) or hexadecimal counting. Sits directly between the board pushbuttons/switches and the display pins. Button inputs are debounced internally.

## Interface

Parameters:
- NUM_DIGITS, 4: number of display digits and counter digits; legal range 1..8.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change; ≥2.
- SCAN_CYCLES, 100_000: clock cycles each digit stays selected; ≥2.
- LEADING_ZERO_BLANK, 0: 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk_i  in  1  system clock. One clock domain.
- reset_n_i  in  1  reset, synchronous, active-low.
- increment_counter_btn_i  in  1  raw pushbutton, count up.
- decrement_counter_btn_i  in  1  raw pushbutton, count down.
- mode_select_switch_i  in  1  raw switch; 0 = decimal, 1 = hex.
- digital_select_o  out  NUM_DIGITS  digit enables, active-low, one-cold.
- seven_bit_display_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- wrap_o  out  1  one-cycle pulse when the counter wraps in either direction.

## Operation

- Inputs: every raw input passes through a 2-flop synchronizer. Buttons then feed a debouncer: debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the debounce count. A 0→1 transition of the debounced level gives a one-cycle press pulse. Release produces nothing.
- Counter: NUM_DIGITS 4-bit digits, digit 0 least significant.
  - Decimal: each digit 0..9; up 9→0 with carry; down 0→9 with borrow.
  - Hex: each digit 0..F; pure binary across all digits.
  - Up at max (all 9s or all Fs) → all zeros, wrap_o=1. Down at all zeros → max, wrap_o=1.
  - Increment and decrement pulses in the same cycle: no change, no wrap.
- Mode change: a change of the synchronized switch clears the counter to zero on the next cycle. Any press pulse in that cycle is discarded. Mode is then applied from that clear onward.
- Scan: a prescaler counts 0..SCAN_CYCLES-1. At terminal count the digit index advances 0→1→…→NUM_DIGITS-1→0.
- Output stage: digital_select_o has bit[index] low and all others high. seven_bit_display_o shows the standard 0–F glyphs of the selected digit.
- Blanking: with LEADING_ZERO_BLANK=1, a zero digit above the most significant nonzero digit drives 7'h7F. Its select stays active.

## Timing

- Reset (reset_n_i low at a clock edge):
  - counter, prescaler and index go to 0;
  - debounced levels go to 0;
  - digital_select_o = all ones;
  - seven_bit_display_o = 7'h7F;
  - wrap_o = 0.
- First cycle after reset release: registered outputs show digit 0 ("0", 7'b1000000) with select bit 0 low.
- Press latency: if a button rises and stays high, the counter value changes exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first sampled high.
- Outputs update one cycle after the counter or index changes. wrap_o is registered and coincides with the cycle the new counter value becomes visible.
- Each digit is selected for exactly SCAN_CYCLES cycles. Selects are glitch-free because all outputs come from flops.
- Reset asserted mid-debounce or mid-scan: everything is discarded, and the above reset values apply.

## Structure

- Shared package seg7_pkg:
  - MODE_DEC/MODE_HEX constants;
  - the 16-entry active-low glyph table and SEG_BLANK = 7'h7F;
  - a hex-to-segment function.
- Sub-module button_debouncer: synchronizer, debounce counter and press-pulse output, parameter DEBOUNCE_CYCLES. Instantiated once per button.
- The mode switch uses a bare 2-flop synchronizer plus edge detect; it is not debounced.

## Test plan

All scenarios use NUM_DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=8.

- Reset held then released → digital_select_o=4'b1111 and segments 7'h7F during reset. Next cycle 4'b1110/7'b1000000. Select rotates 1110→1101→1011→0111 every 8 cycles.
- Increment held 3 cycles → no count. Held 10 cycles → count 0001 exactly 7 cycles after the first high, one increment only. A 1-cycle glitch mid-debounce restarts the count.
- Decimal mode, preset to 0999 by presses, one increment → 1000. At 9999, increment → 0000 with wrap_o one cycle. At 0000, decrement → 9999 with wrap_o.
- Hex mode at 00FF, increment → 0100. At FFFF, increment → 0000 with wrap_o.
- Increment and decrement pulses in the same cycle → count unchanged, wrap_o=0.
- Count 0042, mode switch toggled → count 0000 two cycles after the switch edge. LEADING_ZERO_BLANK=1 with count 0042 → digits 3,2 drive 7'h7F, digit 0 shows "2".
